stream_arbiter: RTL and testbench
=================================

STREAM_ARBITER -- requirements
Module: stream_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, AXI-Stream tdata width for all ports.
REQ-002 Parameter CNT_WIDTH, default 16, width of each per-source packet counter.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 src_en  input  2  per-source enable, bit i gates source i; driven from register_space.
REQ-006 s0_axis_tvalid / s0_axis_tready / s0_axis_tdata / s0_axis_tlast  in/out/in/in  1/1/DATA_WIDTH/1  source 0 slave stream.
REQ-007 s1_axis_tvalid / s1_axis_tready / s1_axis_tdata / s1_axis_tlast  in/out/in/in  1/1/DATA_WIDTH/1  source 1 slave stream.
REQ-008 m_axis_tvalid / m_axis_tready / m_axis_tdata / m_axis_tlast  out/in/out/out  1/1/DATA_WIDTH/1  master stream toward fifo.
REQ-009 grant  output  2  one-hot current owner; 2'b00 when idle.
REQ-010 busy  output  1  high while a packet is in flight (state not IDLE).
REQ-011 pkt_cnt0 / pkt_cnt1  output  CNT_WIDTH  completed-packet counts per source.

Function
REQ-012 FSM states IDLE, GNT0, GNT1; registered state, registered last_src (1 bit).
REQ-013 Request i = src_en[i] & si_axis_tvalid.
REQ-014 IDLE: no request -> stay IDLE; only req0 -> GNT0; only req1 -> GNT1; both -> grant source != last_src (round-robin).
REQ-015 On entry to GNTi, last_src <= i.
REQ-016 In GNTi, m_axis_tvalid/tdata/tlast = si_axis_tvalid/tdata/tlast combinationally; si_axis_tready = m_axis_tready; other source tready = 0.
REQ-017 In IDLE, m_axis_tvalid = 0, both s*_axis_tready = 0, m_axis_tdata = 0, m_axis_tlast = 0.
REQ-018 Beat transfer = m_axis_tvalid & m_axis_tready; GNTi -> IDLE on transfer with tlast = 1; otherwise stay GNTi.
REQ-019 Grant latency: first beat accepted no earlier than the cycle after request seen in IDLE; one idle bubble cycle between consecutive packets.
REQ-020 Ownership is packet-atomic: deassertion of src_en[i] or tvalid gaps during GNTi do not release grant; enable changes take effect only in IDLE.
REQ-021 No beat is dropped, duplicated or reordered; tdata/tlast of the granted source pass unmodified.
REQ-022 pkt_cnt_i increments by 1 on the tlast transfer in GNTi; wraps from all-ones to 0 without flag.
REQ-023 Single-beat packet (tvalid & tlast on first beat): GNTi for one transfer cycle, then IDLE.
REQ-024 Backpressure: m_axis_tready low holds state and counters; granted source sees tready low.
REQ-025 grant = 2'b01 in GNT0, 2'b10 in GNT1, 2'b00 in IDLE; busy = (state != IDLE).

Reset
REQ-026 resetn low asynchronously forces state IDLE, last_src = 1 (source 0 wins first tie), pkt_cnt0 = pkt_cnt1 = 0, grant = 0, busy = 0, all tready/tvalid outputs 0.
REQ-027 Reset mid-packet abandons the packet; no counter update; after release arbitration restarts from IDLE.
REQ-028 Reset deassertion is synchronised by the instantiating design; block samples resetn only as async clear.

Verification
REQ-029 src_en=2'b11, both sources present 3-beat packets continuously, m_axis_tready=1 -> output order S0,S1,S0,S1; one bubble between packets; pkt_cnt0=pkt_cnt1=2 after four packets.
REQ-030 src_en=2'b01, source 1 valid, source 0 idle -> grant stays 2'b00, s1_axis_tready=0, pkt_cnt1 unchanged.
REQ-031 Source 0 sends 4 beats 0xA0..0xA3 with m_axis_tready toggling 1/0 each cycle -> output exactly 0xA0..0xA3, tlast only on 0xA3, pkt_cnt0=1.
REQ-032 src_en cleared to 2'b00 mid-packet on source 1 -> packet completes, grant returns 2'b00, then no new grant.
REQ-033 pkt_cnt0 preloaded via 65535 single-beat packets, one more -> pkt_cnt0=0.
REQ-034 resetn pulsed low after beat 2 of a 5-beat source-0 packet -> outputs zero immediately, counters 0, next tie grants source 0.

Source files
------------

// File: rtl/stream_arbiter_if.sv
// ---------------------------------------------------------------------------
// stream_arbiter_if
// AXI-Stream style handshake bundle used for the arbiter's source and sink
// ports.
//   tvalid  producer -> consumer  beat present
//   tready  consumer -> producer  beat accepted when both high
//   tdata   producer -> consumer  payload, DATA_WIDTH bits
//   tlast   producer -> consumer  final beat of a packet
// Modports:
//   master  the side that produces beats (drives tvalid/tdata/tlast)
//   slave   the side that consumes beats (drives tready)
// ---------------------------------------------------------------------------
interface stream_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32
) ();

    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;

    modport master (
        output tvalid,
        output tdata,
        output tlast,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tlast,
        output tready
    );

endinterface

// File: rtl/stream_arbiter.sv
// ---------------------------------------------------------------------------
// stream_arbiter
// Two-source, packet-atomic, round-robin AXI-Stream arbiter. A source wins the
// output in IDLE and keeps it until its tlast beat is transferred; the
// granted source is passed straight through to the master stream.
//
// Ports:
//   clk        clock, all state on the rising edge
//   resetn     asynchronous active-low clear
//   src_en     per-source enable, only consulted while IDLE
//   s0_axis    source 0 stream (slave modport: arbiter drives tready)
//   s1_axis    source 1 stream (slave modport: arbiter drives tready)
//   m_axis     output stream toward the fifo (master modport)
//   grant      one-hot owner, 2'b01 source 0, 2'b10 source 1, 2'b00 idle
//   busy       high while a packet owns the output
//   pkt_cnt0   completed packets from source 0 (wrapping)
//   pkt_cnt1   completed packets from source 1 (wrapping)
// ---------------------------------------------------------------------------
module stream_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [1:0]           src_en,
    stream_arbiter_if.slave      s0_axis,
    stream_arbiter_if.slave      s1_axis,
    stream_arbiter_if.master     m_axis,
    output logic [1:0]           grant,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] pkt_cnt0,
    output logic [CNT_WIDTH-1:0] pkt_cnt1
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t                 state_q,    state_d;
    logic                   last_src_q, last_src_d;
    logic [CNT_WIDTH-1:0]   cnt0_q,     cnt0_d;
    logic [CNT_WIDTH-1:0]   cnt1_q,     cnt1_d;

    logic                   req0;
    logic                   req1;

    logic                   m_tvalid_c;
    logic [DATA_WIDTH-1:0]  m_tdata_c;
    logic                   m_tlast_c;
    logic                   s0_tready_c;
    logic                   s1_tready_c;

    // Requests are only meaningful while IDLE; ownership ignores them.
    assign req0 = src_en[0] & s0_axis.tvalid;
    assign req1 = src_en[1] & s1_axis.tvalid;

    // State, round-robin pointer and packet counters.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            last_src_q <= 1'b1;   // source 0 wins the first tie
            cnt0_q     <= '0;
            cnt1_q     <= '0;
        end else begin
            state_q    <= state_d;
            last_src_q <= last_src_d;
            cnt0_q     <= cnt0_d;
            cnt1_q     <= cnt1_d;
        end
    end

    // Next-state, pass-through mux and counter updates.
    always_comb begin
        state_d     = state_q;
        last_src_d  = last_src_q;
        cnt0_d      = cnt0_q;
        cnt1_d      = cnt1_q;
        m_tvalid_c  = 1'b0;
        m_tdata_c   = '0;
        m_tlast_c   = 1'b0;
        s0_tready_c = 1'b0;
        s1_tready_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0 && req1) begin
                    // Tie: serve whichever source did not own the last packet.
                    if (last_src_q) begin
                        state_d    = GNT0;
                        last_src_d = 1'b0;
                    end else begin
                        state_d    = GNT1;
                        last_src_d = 1'b1;
                    end
                end else if (req0) begin
                    state_d    = GNT0;
                    last_src_d = 1'b0;
                end else if (req1) begin
                    state_d    = GNT1;
                    last_src_d = 1'b1;
                end
            end

            GNT0: begin
                m_tvalid_c  = s0_axis.tvalid;
                m_tdata_c   = s0_axis.tdata;
                m_tlast_c   = s0_axis.tlast;
                s0_tready_c = m_axis.tready;
                // Release only on the transferred tlast beat.
                if (s0_axis.tvalid && m_axis.tready && s0_axis.tlast) begin
                    state_d = IDLE;
                    cnt0_d  = cnt0_q + CNT_WIDTH'(1);
                end
            end

            GNT1: begin
                m_tvalid_c  = s1_axis.tvalid;
                m_tdata_c   = s1_axis.tdata;
                m_tlast_c   = s1_axis.tlast;
                s1_tready_c = m_axis.tready;
                if (s1_axis.tvalid && m_axis.tready && s1_axis.tlast) begin
                    state_d = IDLE;
                    cnt1_d  = cnt1_q + CNT_WIDTH'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Stream outputs follow the granted source within the cycle.
    assign m_axis.tvalid  = m_tvalid_c;
    assign m_axis.tdata   = m_tdata_c;
    assign m_axis.tlast   = m_tlast_c;
    assign s0_axis.tready = s0_tready_c;
    assign s1_axis.tready = s1_tready_c;

    // Status decoded from the state register only.
    assign grant    = {state_q == GNT1, state_q == GNT0};
    assign busy     = (state_q != IDLE);
    assign pkt_cnt0 = cnt0_q;
    assign pkt_cnt1 = cnt1_q;

endmodule

// File: tb/tb_stream_arbiter.sv
// ---------------------------------------------------------------------------
// tb_stream_arbiter
// Directed per-cycle vector table for arbitration, pass-through, backpressure
// and enable handling, followed by hand-written sequences for counter wrap,
// single-beat packets and mid-packet reset.
// ---------------------------------------------------------------------------
module tb_stream_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 8;

    logic          clk;
    logic          resetn;
    logic [1:0]    src_en;
    logic [1:0]    grant;
    logic          busy;
    logic [CW-1:0] pkt_cnt0;
    logic [CW-1:0] pkt_cnt1;

    stream_arbiter_if #(.DATA_WIDTH(DW)) s0_if ();
    stream_arbiter_if #(.DATA_WIDTH(DW)) s1_if ();
    stream_arbiter_if #(.DATA_WIDTH(DW)) m_if ();

    stream_arbiter #(
        .DATA_WIDTH(DW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .src_en  (src_en),
        .s0_axis (s0_if),
        .s1_axis (s1_if),
        .m_axis  (m_if),
        .grant   (grant),
        .busy    (busy),
        .pkt_cnt0(pkt_cnt0),
        .pkt_cnt1(pkt_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    en;
        logic          v0;
        logic [DW-1:0] d0;
        logic          l0;
        logic          v1;
        logic [DW-1:0] d1;
        logic          l1;
        logic          rdy;
        logic [1:0]    g;
        logic          bsy;
        logic          mv;
        logic [DW-1:0] md;
        logic          ml;
        logic          r0;
        logic          r1;
        logic [CW-1:0] c0;
        logic [CW-1:0] c1;
    } vec_t;

    vec_t vq[$];
    int   n_cmp;
    int   n_err;
    int   single_err;

    function automatic vec_t mk(
        input logic [1:0] en,
        input logic v0, input logic [DW-1:0] d0, input logic l0,
        input logic v1, input logic [DW-1:0] d1, input logic l1,
        input logic rdy,
        input logic [1:0] g, input logic bsy, input logic mv,
        input logic [DW-1:0] md, input logic ml,
        input logic r0, input logic r1,
        input logic [CW-1:0] c0, input logic [CW-1:0] c1);
        vec_t v;
        v.en = en; v.v0 = v0; v.d0 = d0; v.l0 = l0;
        v.v1 = v1; v.d1 = d1; v.l1 = l1; v.rdy = rdy;
        v.g = g; v.bsy = bsy; v.mv = mv; v.md = md; v.ml = ml;
        v.r0 = r0; v.r1 = r1; v.c0 = c0; v.c1 = c1;
        return v;
    endfunction

    function automatic logic [54:0] snap();
        return {grant, busy, m_if.tvalid, m_if.tdata, m_if.tlast,
                s0_if.tready, s1_if.tready, pkt_cnt0, pkt_cnt1};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One single-beat packet from source 0; logs handshake or data problems.
    task automatic send_s0_single(input logic [DW-1:0] d);
        bit got;
        got = 1'b0;
        s0_if.tvalid = 1'b1;
        s0_if.tdata  = d;
        s0_if.tlast  = 1'b1;
        for (int k = 0; k < 6 && !got; k++) begin
            @(negedge clk);
            #1;
            if (s0_if.tready && m_if.tvalid) begin
                got = 1'b1;
                if (m_if.tdata !== d || m_if.tlast !== 1'b1 || grant !== 2'b01)
                    single_err++;
            end
        end
        if (!got) single_err++;
        @(posedge clk);
        #1;
        s0_if.tvalid = 1'b0;
        s0_if.tlast  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int beat;
        n_cmp = 0;
        n_err = 0;
        single_err = 0;

        resetn = 1'b0;
        src_en = 2'b00;
        s0_if.tvalid = 1'b0; s0_if.tdata = '0; s0_if.tlast = 1'b0;
        s1_if.tvalid = 1'b0; s1_if.tdata = '0; s1_if.tlast = 1'b0;
        m_if.tready  = 1'b0;
        #3;
        check("reset_state", 64'(snap()), 64'(0));
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;

        // Both sources with 3-beat packets: S0,S1,S0,S1 with one bubble each.
        vq.push_back(mk(2'b11, 1'b1,32'h10,1'b0, 1'b1,32'h20,1'b0, 1'b1, 2'b00,1'b0,1'b0,32'h00,1'b0, 1'b0,1'b0, 8'd0,8'd0));
        vq.push_back(mk(2'b11, 1'b1,32'h10,1'b0, 1'b1,32'h20,1'b0, 1'b1, 2'b01,1'b1,1'b1,32'h10,1'b0, 1'b1,1'b0, 8'd0,8'd0));
        vq.push_back(mk(2'b11, 1'b1,32'h11,1'b0, 1'b1,32'h20,1'b0, 1'b1, 2'b01,1'b1,1'b1,32'h11,1'b0, 1'b1,1'b0, 8'd0,8'd0));
        vq.push_back(mk(2'b11, 1'b1,32'h12,1'b1, 1'b1,32'h20,1'b0, 1'b1, 2'b01,1'b1,1'b1,32'h12,1'b1, 1'b1,1'b0, 8'd0,8'd0));
        vq.push_back(mk(2'b11, 1'b1,32'h10,1'b0, 1'b1,32'h20,1'b0, 1'b1, 2'b00,1'b0,1'b0,32'h00,1'b0, 1'b0,1'b0, 8'd1,8'd0));
        vq.push_back(mk(2'b11, 1'b1,32'h10,1'b0, 1'b1,32'h20,1'b0, 1'b1, 2'b10,1'b1,1'b1,32'h20,1'b0, 1'b0,1'b1, 8'd1,8'd0));
        vq.push_back(mk(2'b11, 1'b1,32'h10,1'b0, 1'b1,32'h21,1'b0, 1'b1, 2'b10,1'b1,1'b1,32'h21,1'b0, 1'b0,1'b1, 8'd1,8'd0));
        vq.push_back(mk(2'b11, 1'b1,32'h10,1'b0, 1'b1,32'h22,1'b1, 1'b1, 2'b10,1'b1,1'b1,32'h22,1'b1, 1'b0,1'b1, 8'd1,8'd0));
        vq.push_back(mk(2'b11, 1'b1,32'h10,1'b0, 1'b1,32'h20,1'b0, 1'b1, 2'b00,1'b0,1'b0,32'h00,1'b0, 1'b0,1'b0, 8'd1,8'd1));
        vq.push_back(mk(2'b11, 1'b1,32'h10,1'b0, 1'b1,32'h20,1'b0, 1'b1, 2'b01,1'b1,1'b1,32'h10,1'b0, 1'b1,1'b0, 8'd1,8'd1));
        vq.push_back(mk(2'b11, 1'b1,32'h11,1'b0, 1'b1,32'h20,1'b0, 1'b1, 2'b01,1'b1,1'b1,32'h11,1'b0, 1'b1,1'b0, 8'd1,8'd1));
        vq.push_back(mk(2'b11, 1'b1,32'h12,1'b1, 1'b1,32'h20,1'b0, 1'b1, 2'b01,1'b1,1'b1,32'h12,1'b1, 1'b1,1'b0, 8'd1,8'd1));
        vq.push_back(mk(2'b11, 1'b1,32'h10,1'b0, 1'b1,32'h20,1'b0, 1'b1, 2'b00,1'b0,1'b0,32'h00,1'b0, 1'b0,1'b0, 8'd2,8'd1));
        vq.push_back(mk(2'b11, 1'b1,32'h10,1'b0, 1'b1,32'h20,1'b0, 1'b1, 2'b10,1'b1,1'b1,32'h20,1'b0, 1'b0,1'b1, 8'd2,8'd1));
        vq.push_back(mk(2'b11, 1'b1,32'h10,1'b0, 1'b1,32'h21,1'b0, 1'b1, 2'b10,1'b1,1'b1,32'h21,1'b0, 1'b0,1'b1, 8'd2,8'd1));
        vq.push_back(mk(2'b11, 1'b1,32'h10,1'b0, 1'b1,32'h22,1'b1, 1'b1, 2'b10,1'b1,1'b1,32'h22,1'b1, 1'b0,1'b1, 8'd2,8'd1));
        vq.push_back(mk(2'b00, 1'b1,32'h10,1'b0, 1'b1,32'h20,1'b0, 1'b1, 2'b00,1'b0,1'b0,32'h00,1'b0, 1'b0,1'b0, 8'd2,8'd2));
        // Source 1 valid but disabled: no grant.
        vq.push_back(mk(2'b01, 1'b0,32'h00,1'b0, 1'b1,32'h30,1'b1, 1'b1, 2'b00,1'b0,1'b0,32'h00,1'b0, 1'b0,1'b0, 8'd2,8'd2));
        vq.push_back(mk(2'b01, 1'b0,32'h00,1'b0, 1'b1,32'h30,1'b1, 1'b1, 2'b00,1'b0,1'b0,32'h00,1'b0, 1'b0,1'b0, 8'd2,8'd2));
        // Source 0, 4 beats A0..A3, tready toggling 1/0.
        vq.push_back(mk(2'b01, 1'b1,32'hA0,1'b0, 1'b1,32'h30,1'b1, 1'b1, 2'b00,1'b0,1'b0,32'h00,1'b0, 1'b0,1'b0, 8'd2,8'd2));
        vq.push_back(mk(2'b01, 1'b1,32'hA0,1'b0, 1'b1,32'h30,1'b1, 1'b0, 2'b01,1'b1,1'b1,32'hA0,1'b0, 1'b0,1'b0, 8'd2,8'd2));
        vq.push_back(mk(2'b01, 1'b1,32'hA0,1'b0, 1'b1,32'h30,1'b1, 1'b1, 2'b01,1'b1,1'b1,32'hA0,1'b0, 1'b1,1'b0, 8'd2,8'd2));
        vq.push_back(mk(2'b01, 1'b1,32'hA1,1'b0, 1'b1,32'h30,1'b1, 1'b0, 2'b01,1'b1,1'b1,32'hA1,1'b0, 1'b0,1'b0, 8'd2,8'd2));
        vq.push_back(mk(2'b01, 1'b1,32'hA1,1'b0, 1'b1,32'h30,1'b1, 1'b1, 2'b01,1'b1,1'b1,32'hA1,1'b0, 1'b1,1'b0, 8'd2,8'd2));
        vq.push_back(mk(2'b01, 1'b1,32'hA2,1'b0, 1'b1,32'h30,1'b1, 1'b0, 2'b01,1'b1,1'b1,32'hA2,1'b0, 1'b0,1'b0, 8'd2,8'd2));
        vq.push_back(mk(2'b01, 1'b1,32'hA2,1'b0, 1'b1,32'h30,1'b1, 1'b1, 2'b01,1'b1,1'b1,32'hA2,1'b0, 1'b1,1'b0, 8'd2,8'd2));
        vq.push_back(mk(2'b01, 1'b1,32'hA3,1'b1, 1'b1,32'h30,1'b1, 1'b0, 2'b01,1'b1,1'b1,32'hA3,1'b1, 1'b0,1'b0, 8'd2,8'd2));
        vq.push_back(mk(2'b01, 1'b1,32'hA3,1'b1, 1'b1,32'h30,1'b1, 1'b1, 2'b01,1'b1,1'b1,32'hA3,1'b1, 1'b1,1'b0, 8'd2,8'd2));
        vq.push_back(mk(2'b01, 1'b0,32'h00,1'b0, 1'b1,32'h30,1'b1, 1'b0, 2'b00,1'b0,1'b0,32'h00,1'b0, 1'b0,1'b0, 8'd3,8'd2));
        // Source 1 packet with enable dropped and a tvalid gap mid-packet.
        vq.push_back(mk(2'b10, 1'b0,32'h00,1'b0, 1'b1,32'h40,1'b0, 1'b1, 2'b00,1'b0,1'b0,32'h00,1'b0, 1'b0,1'b0, 8'd3,8'd2));
        vq.push_back(mk(2'b10, 1'b0,32'h00,1'b0, 1'b1,32'h40,1'b0, 1'b1, 2'b10,1'b1,1'b1,32'h40,1'b0, 1'b0,1'b1, 8'd3,8'd2));
        vq.push_back(mk(2'b00, 1'b0,32'h00,1'b0, 1'b1,32'h41,1'b0, 1'b1, 2'b10,1'b1,1'b1,32'h41,1'b0, 1'b0,1'b1, 8'd3,8'd2));
        vq.push_back(mk(2'b00, 1'b0,32'h00,1'b0, 1'b0,32'h00,1'b0, 1'b1, 2'b10,1'b1,1'b0,32'h00,1'b0, 1'b0,1'b1, 8'd3,8'd2));
        vq.push_back(mk(2'b00, 1'b0,32'h00,1'b0, 1'b1,32'h42,1'b1, 1'b1, 2'b10,1'b1,1'b1,32'h42,1'b1, 1'b0,1'b1, 8'd3,8'd2));
        vq.push_back(mk(2'b00, 1'b1,32'h50,1'b0, 1'b1,32'h50,1'b0, 1'b1, 2'b00,1'b0,1'b0,32'h00,1'b0, 1'b0,1'b0, 8'd3,8'd3));
        vq.push_back(mk(2'b00, 1'b1,32'h50,1'b0, 1'b1,32'h50,1'b0, 1'b1, 2'b00,1'b0,1'b0,32'h00,1'b0, 1'b0,1'b0, 8'd3,8'd3));

        foreach (vq[i]) begin
            @(negedge clk);
            src_en       = vq[i].en;
            s0_if.tvalid = vq[i].v0; s0_if.tdata = vq[i].d0; s0_if.tlast = vq[i].l0;
            s1_if.tvalid = vq[i].v1; s1_if.tdata = vq[i].d1; s1_if.tlast = vq[i].l1;
            m_if.tready  = vq[i].rdy;
            #2;
            check($sformatf("vec%0d", i), 64'(snap()),
                  64'({vq[i].g, vq[i].bsy, vq[i].mv, vq[i].md, vq[i].ml,
                       vq[i].r0, vq[i].r1, vq[i].c0, vq[i].c1}));
        end

        // Counter wrap with back-to-back single-beat packets on source 0.
        @(negedge clk);
        src_en = 2'b01;
        s0_if.tvalid = 1'b0; s0_if.tlast = 1'b0;
        s1_if.tvalid = 1'b0; s1_if.tdata = '0; s1_if.tlast = 1'b0;
        m_if.tready  = 1'b1;
        for (int p = 0; p < 252; p++) send_s0_single(DW'(32'h100 + p));
        check("cnt0_all_ones", 64'(pkt_cnt0), 64'(8'hFF));
        send_s0_single(32'h1FF);
        check("single_handshakes", 64'(single_err), 64'(0));
        check("cnt_wrap_idle", 64'({grant, busy, pkt_cnt0, pkt_cnt1}),
              64'({2'b00, 1'b0, 8'h00, 8'h03}));

        // Mid-packet reset after two beats of a five-beat source-0 packet.
        s0_if.tvalid = 1'b1; s0_if.tdata = 32'h60; s0_if.tlast = 1'b0;
        beat = 0;
        for (int k = 0; k < 40 && beat < 2; k++) begin
            @(negedge clk);
            #1;
            if (s0_if.tready && m_if.tvalid) begin
                @(posedge clk);
                #1;
                beat++;
                s0_if.tdata = DW'(32'h60 + beat);
            end
        end
        check("rst_pre_beats", 64'(beat), 64'(2));
        check("rst_pre_owner", 64'({grant, busy}), 64'({2'b01, 1'b1}));
        #2;
        resetn = 1'b0;
        #1;
        check("rst_async_clear", 64'(snap()), 64'(0));
        @(negedge clk);
        resetn = 1'b1;
        src_en = 2'b11;
        s0_if.tvalid = 1'b1; s0_if.tdata = 32'h70; s0_if.tlast = 1'b1;
        s1_if.tvalid = 1'b1; s1_if.tdata = 32'h80; s1_if.tlast = 1'b1;
        @(negedge clk);
        #1;
        check("rst_tie_src0", 64'(snap()),
              64'({2'b01, 1'b1, 1'b1, 32'h70, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0}));
        @(negedge clk);
        #1;
        check("rst_bubble", 64'(snap()),
              64'({2'b00, 1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 8'd1, 8'd0}));
        @(negedge clk);
        #1;
        check("rst_rr_src1", 64'(snap()),
              64'({2'b10, 1'b1, 1'b1, 32'h80, 1'b1, 1'b0, 1'b1, 8'd1, 8'd0}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
